// File: rtl/onchip_memory_dp.sv
// rtl/onchip_memory_dp.sv - dual-port on-chip RAM with byte enables and pipelined reads
//
// Optional feature macro: ONCHIP_MEMORY_DP_CLEAR_EN (adds a post-reset clear FSM).
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   reset_req                  gates both port clock enables
//   freeze                     suppresses writes on both ports
//   address/address2           word address, port 1 / port 2
//   chipselect/chipselect2     access request
//   write/write2               1 = write, 0 = read
//   byteenable/byteenable2     write byte lanes
//   writedata/writedata2       write data
//   clken/clken2               per-port clock enable
//   readdata/readdata2         read data, held between reads
//   readdatavalid/2            one-cycle pulse qualifying readdata
//   waitrequest/2              high = command not accepted
module onchip_memory_dp #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "onchip_memory_dp.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic                freeze,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    input  logic [ADDR_W-1:0]   address2,
    input  logic                chipselect2,
    input  logic                write2,
    input  logic [DATA_W/8-1:0] byteenable2,
    input  logic [DATA_W-1:0]   writedata2,
    input  logic                clken2,
    output logic [DATA_W-1:0]   readdata2,
    output logic                readdatavalid2,
    output logic                waitrequest2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    // Power-up contents are attached for the vendor RAM inference flow.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;

`ifdef ONCHIP_MEMORY_DP_CLEAR_EN
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_addr_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        clearing     = 1'b0;
        case (state)
            ST_CLEAR: begin
                clearing     = 1'b1;
                clr_addr_nxt = clr_addr + 1'b1;
                if (&clr_addr) state_nxt = ST_IDLE;
            end
            default: ;
        endcase
    end

    // Commands are refused while reset is held and until the sweep finishes.
    assign busy = reset | (state == ST_CLEAR);
`else
    assign busy     = 1'b0;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign waitrequest  = busy;
    assign waitrequest2 = busy;

    logic [1:0]        en, acc, rd_acc, wr_acc;
    logic [ADDR_W-1:0] addr_p [2];

    assign en[0]     = clken & ~reset_req;
    assign en[1]     = clken2 & ~reset_req;
    assign acc[0]    = chipselect & en[0] & ~busy;
    assign acc[1]    = chipselect2 & en[1] & ~busy;
    assign rd_acc[0] = acc[0] & ~write;
    assign rd_acc[1] = acc[1] & ~write2;
    assign wr_acc[0] = acc[0] & write & ~freeze;
    assign wr_acc[1] = acc[1] & write2 & ~freeze;
    assign addr_p[0] = address;
    assign addr_p[1] = address2;

    // Port 2 lanes are scheduled first so a port 1 write to the same lane
    // overrides it; lanes only port 2 enables keep port 2 data.
    always_ff @(posedge clk) begin
        if (clearing && !reset) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (wr_acc[1] && byteenable2[b])
                    mem[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
                if (wr_acc[0] && byteenable[b])
                    mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

    // Read pipelines: stages advance only while the port is enabled; the
    // output valid drops to 0 when stalled so a held read pulses just once.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_W-1:0] rdata_q;
        logic              rvalid_q;

        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] mid_data;
            logic              mid_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    mid_valid <= 1'b0;
                    mid_data  <= '0;
                    rvalid_q  <= 1'b0;
                    rdata_q   <= '0;
                end else if (en[p]) begin
                    mid_valid <= rd_acc[p];
                    if (rd_acc[p]) mid_data <= mem[addr_p[p]];
                    rvalid_q <= mid_valid;
                    if (mid_valid) rdata_q <= mid_data;
                end else begin
                    rvalid_q <= 1'b0;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else if (en[p]) begin
                    rvalid_q <= rd_acc[p];
                    if (rd_acc[p]) rdata_q <= mem[addr_p[p]];
                end else begin
                    rvalid_q <= 1'b0;
                end
            end
        end

        if (p == 0) begin : g_out1
            assign readdata      = rdata_q;
            assign readdatavalid = rvalid_q;
        end else begin : g_out2
            assign readdata2      = rdata_q;
            assign readdatavalid2 = rvalid_q;
        end
    end

endmodule

// File: tb/tb_onchip_memory_dp.sv
// tb/tb_onchip_memory_dp.sv - directed self-checking bench for onchip_memory_dp
module tb_onchip_memory_dp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, reset_req = 1'b0, freeze = 1'b0;
    // DUT A: READ_LATENCY = 1, both ports
    logic [9:0]  a_addr = '0, a_addr2 = '0;
    logic        a_cs = 0, a_cs2 = 0, a_wr = 0, a_wr2 = 0, a_ck = 1, a_ck2 = 1;
    logic [3:0]  a_be = '0, a_be2 = '0;
    logic [31:0] a_wd = '0, a_wd2 = '0;
    logic [31:0] a_rd, a_rd2;
    logic        a_rdv, a_rdv2, a_wait, a_wait2;
    // DUT B: READ_LATENCY = 2, port 1 only
    logic [9:0]  b_addr = '0;
    logic        b_cs = 0, b_wr = 0, b_ck = 1;
    logic [31:0] b_wd = '0;
    logic [31:0] b_rd, b_rd2;
    logic        b_rdv, b_rdv2, b_wait, b_wait2;

    int n_vec = 0;
    int n_bad = 0;

    onchip_memory_dp #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .reset(reset), .reset_req(reset_req), .freeze(freeze),
        .address(a_addr), .chipselect(a_cs), .write(a_wr), .byteenable(a_be),
        .writedata(a_wd), .clken(a_ck), .readdata(a_rd), .readdatavalid(a_rdv),
        .waitrequest(a_wait),
        .address2(a_addr2), .chipselect2(a_cs2), .write2(a_wr2), .byteenable2(a_be2),
        .writedata2(a_wd2), .clken2(a_ck2), .readdata2(a_rd2), .readdatavalid2(a_rdv2),
        .waitrequest2(a_wait2)
    );

    onchip_memory_dp #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(2)) u_dut_b (
        .clk(clk), .reset(reset), .reset_req(1'b0), .freeze(1'b0),
        .address(b_addr), .chipselect(b_cs), .write(b_wr), .byteenable(4'hF),
        .writedata(b_wd), .clken(b_ck), .readdata(b_rd), .readdatavalid(b_rdv),
        .waitrequest(b_wait),
        .address2(10'd0), .chipselect2(1'b0), .write2(1'b0), .byteenable2(4'h0),
        .writedata2(32'd0), .clken2(1'b1), .readdata2(b_rd2), .readdatavalid2(b_rdv2),
        .waitrequest2(b_wait2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic a_write1(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] be);
        a_cs = 1; a_wr = 1; a_addr = ad; a_wd = d; a_be = be;
        tick();
        a_cs = 0; a_wr = 0;
    endtask

    task automatic a_read1(input string tag, input logic [9:0] ad, input logic [31:0] exp);
        a_cs = 1; a_wr = 0; a_addr = ad;
        tick();
        a_cs = 0;
        check({tag, "_rdv"}, 32'(a_rdv), 32'd1);
        check(tag, a_rd, exp);
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (a_wait && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd1024);
    endtask

    initial begin
        tick(); tick();
        check("rst_rdv", 32'(a_rdv), 32'd0);
        check("rst_rdv2", 32'(a_rdv2), 32'd0);
        check("rst_rd", a_rd, 32'd0);
        check("rst_rd2", a_rd2, 32'd0);
        check("rst_wait_in_reset", 32'(a_wait), 32'd0
`ifdef ONCHIP_MEMORY_DP_CLEAR_EN
              | 32'd1
`endif
        );
        reset = 0;
`ifdef ONCHIP_MEMORY_DP_CLEAR_EN
        wait_clear("clear_len1");
        a_write1(10'd7, 32'h7777_7777, 4'hF);
        a_read1("pre_clear7", 10'd7, 32'h7777_7777);
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 500; i++) tick();
        check("clear_wait_mid", 32'(a_wait2), 32'd1);
        reset = 1; tick(); reset = 0;
        wait_clear("clear_len2");
        a_read1("post_clear7", 10'd7, 32'd0);
        a_read1("post_clear1023", 10'd1023, 32'd0);
`else
        check("wait_const", 32'(a_wait), 32'd0);
        check("wait2_const", 32'(a_wait2), 32'd0);
`endif

        // port 1 write, port 2 read, one-cycle latency, then hold
        a_write1(10'd5, 32'hDEAD_BEEF, 4'hF);
        a_cs2 = 1; a_wr2 = 0; a_addr2 = 10'd5;
        tick();
        a_cs2 = 0;
        check("p2_rdv", 32'(a_rdv2), 32'd1);
        check("p2_rd", a_rd2, 32'hDEAD_BEEF);
        tick();
        check("p2_rdv_drop", 32'(a_rdv2), 32'd0);
        check("p2_rd_hold", a_rd2, 32'hDEAD_BEEF);

        // same-cycle dual write collisions
        a_cs = 1; a_wr = 1; a_addr = 10'd9; a_wd = 32'h1122_3344; a_be = 4'hF;
        a_cs2 = 1; a_wr2 = 1; a_addr2 = 10'd9; a_wd2 = 32'hAABB_CCDD; a_be2 = 4'hC;
        tick();
        a_addr = 10'd10; a_be = 4'h3; a_addr2 = 10'd10;
        tick();
        a_cs = 0; a_wr = 0; a_cs2 = 0; a_wr2 = 0;
        a_read1("collide_full", 10'd9, 32'h1122_3344);
        a_read1("collide_split", 10'd10, 32'hAABB_3344);

        // freeze suppresses the write
        a_write1(10'd3, 32'h7, 4'hF);
        freeze = 1;
        a_write1(10'd3, 32'h5, 4'hF);
        freeze = 0;
        a_read1("freeze", 10'd3, 32'h7);

        // partial byte lanes
        a_write1(10'd20, 32'hFFFF_FFFF, 4'hF);
        a_write1(10'd20, 32'h1234_5678, 4'h5);
        a_read1("byte_lanes", 10'd20, 32'hFF34_FF78);

        // read-during-write on the other port returns old data
        a_cs = 1; a_wr = 1; a_addr = 10'd5; a_wd = 32'hCAFE_F00D; a_be = 4'hF;
        a_cs2 = 1; a_wr2 = 0; a_addr2 = 10'd5;
        tick();
        a_cs = 0; a_wr = 0; a_cs2 = 0;
        check("rdw_old", a_rd2, 32'hDEAD_BEEF);
        a_read1("rdw_new", 10'd5, 32'hCAFE_F00D);

        // back-to-back reads, no bubbles
        a_cs = 1; a_wr = 0; a_addr = 10'd3;
        tick(); check("b2b0_rdv", 32'(a_rdv), 32'd1); check("b2b0", a_rd, 32'h7);
        a_addr = 10'd9;
        tick(); check("b2b1_rdv", 32'(a_rdv), 32'd1); check("b2b1", a_rd, 32'h1122_3344);
        a_addr = 10'd10;
        tick(); check("b2b2_rdv", 32'(a_rdv), 32'd1); check("b2b2", a_rd, 32'hAABB_3344);
        a_cs = 0;

        // address extremes and reset_req gating
        a_write1(10'd1023, 32'h0BAD_F00D, 4'hF);
        a_write1(10'd0, 32'h0000_1111, 4'hF);
        reset_req = 1;
        a_write1(10'd0, 32'h0000_2222, 4'hF);
        a_cs = 1; a_addr = 10'd0;
        tick();
        a_cs = 0;
        check("rreq_no_rdv", 32'(a_rdv), 32'd0);
        reset_req = 0;
        a_read1("addr_max", 10'd1023, 32'h0BAD_F00D);
        a_read1("rreq_no_write", 10'd0, 32'h0000_1111);

`ifndef ONCHIP_MEMORY_DP_CLEAR_EN
        reset = 1; tick(); reset = 0;
        check("rst_rd_zero", a_rd, 32'd0);
        a_read1("rst_keeps_mem", 10'd9, 32'h1122_3344);
`endif

        // latency 2 with a two-cycle clock-enable stall
        b_cs = 1; b_wr = 1;
        b_addr = 10'd0; b_wd = 32'h0A0A_0A0A; tick();
        b_addr = 10'd1; b_wd = 32'h1B1B_1B1B; tick();
        b_addr = 10'd2; b_wd = 32'h2C2C_2C2C; tick();
        b_wr = 0; b_addr = 10'd0;
        tick(); check("l2_e0_rdv", 32'(b_rdv), 32'd0);
        b_addr = 10'd1;
        tick(); check("l2_e1_rdv", 32'(b_rdv), 32'd1); check("l2_e1_rd", b_rd, 32'h0A0A_0A0A);
        b_ck = 0; b_addr = 10'd2;
        tick(); check("l2_e2_rdv", 32'(b_rdv), 32'd0);
        tick(); check("l2_e3_rdv", 32'(b_rdv), 32'd0);
        b_ck = 1;
        tick(); check("l2_e4_rdv", 32'(b_rdv), 32'd1); check("l2_e4_rd", b_rd, 32'h1B1B_1B1B);
        b_cs = 0;
        tick(); check("l2_e5_rdv", 32'(b_rdv), 32'd1); check("l2_e5_rd", b_rd, 32'h2C2C_2C2C);
        tick(); check("l2_e6_rdv", 32'(b_rdv), 32'd0); check("l2_e6_hold", b_rd, 32'h2C2C_2C2C);

        // reset discards an in-flight read
        b_cs = 1; b_addr = 10'd1;
        tick();
        b_cs = 0; reset = 1;
        tick();
        check("flush_rdv", 32'(b_rdv), 32'd0);
        check("flush_rd", b_rd, 32'd0);
        reset = 0;
        tick(); check("flush_rdv_after", 32'(b_rdv), 32'd0);
        tick(); check("flush_rdv_after2", 32'(b_rdv), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/onchip_memory_dp.md
ONCHIP_MEMORY_DP -- requirements
Module: onchip_memory_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10, word address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter INIT_FILE, default "onchip_memory_dp.hex", power-up contents.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- reset_req  in  1  high gates both port clock enables.
- freeze  in  1  high suppresses writes on both ports.
- address / address2  in  ADDR_W  port 1 / port 2 word address.
- chipselect / chipselect2  in  1  access request.
- write / write2  in  1  1 = write, 0 = read, when selected.
- byteenable / byteenable2  in  DATA_W/8  write byte lanes.
- writedata / writedata2  in  DATA_W  write data.
- clken / clken2  in  1  per-port clock enable.
- readdata / readdata2  out  DATA_W  read data.
- readdatavalid / readdatavalid2  out  1  one-cycle pulse qualifying readdata.
- waitrequest / waitrequest2  out  1  high = command not accepted.

Function
REQ-007 Port N enable en_N SHALL be clkenN & ~reset_req; accept_N = chipselectN & en_N & ~waitrequestN.
REQ-008 An accepted write SHALL update only the enabled byte lanes at the rising edge, unless freeze=1, in which case memory is unchanged.
REQ-009 An accepted read SHALL drive readdata and pulse readdatavalid exactly READ_LATENCY cycles later.
REQ-010 With en_N=0, port N's read pipeline SHALL hold (no advance, no readdatavalid pulse); the pulse emerges once en_N returns.
REQ-011 readdata SHALL hold its last value between reads; readdatavalid SHALL be 0 when not pulsing.
REQ-012 Read-during-write, same or other port, same address: the read SHALL return old data.
REQ-013 Both ports writing the same address in the same cycle: port 1 data SHALL win on lanes it enables; lanes enabled only by port 2 take port 2 data.
REQ-014 Back-to-back reads SHALL sustain one accepted read per cycle per port, with no bubbles.
REQ-015 Addresses SHALL be full-range; no wrap or out-of-range case exists.

Reset
REQ-016 reset SHALL clear both readdatavalid outputs and all pipeline valid bits.
REQ-017 reset SHALL set both readdata outputs to 0.
REQ-018 reset SHALL discard in-flight reads, which never produce a readdatavalid pulse.
REQ-019 reset alone SHALL NOT alter memory contents.

Configuration
REQ-020 Macro ONCHIP_MEMORY_DP_CLEAR_EN, when defined, SHALL add a clear FSM:
- IDLE/CLEAR; reset forces CLEAR with counter 0.
- Each cycle in CLEAR writes 0 to the counter address (ignores en_N and freeze) and increments.
- After writing DEPTH-1, moves to IDLE.
- Both waitrequest outputs are 1 during reset and CLEAR; commands are ignored.
- Reset mid-clear restarts at 0.
REQ-021 Without ONCHIP_MEMORY_DP_CLEAR_EN:
- No clear FSM; contents come only from INIT_FILE.
- waitrequest and waitrequest2 are constant 0.

Verification
REQ-022 Write 0xDEADBEEF to addr 5 on port 1, then read addr 5 on port 2 with READ_LATENCY=1: readdata2=0xDEADBEEF, readdatavalid2 pulses 1 cycle after accept.
REQ-023 Port 1 writes 0x11223344 (be=0xF) and port 2 writes 0xAABBCCDD (be=0xC) to addr 9 in the same cycle: subsequent read of addr 9 returns 0x11223344.
REQ-024 READ_LATENCY=2, reads of addr 0,1,2 on consecutive cycles with clken dropped for 2 cycles after the second read: three readdatavalid pulses, in order, with the third delayed 2 cycles.
REQ-025 freeze=1 during a write of 0x5 to addr 3 holding 0x7: readback is 0x7.
REQ-026 With ONCHIP_MEMORY_DP_CLEAR_EN and DEPTH=1024:
- Reset is released with nonzero contents; waitrequest stays high 1024 cycles, then every address reads 0.
- A second reset at cycle 500 restarts the 1024-cycle count.
